// File: rtl/shared_timer_pkg.sv
// Shared definitions for the shared timer arbiter: FSM state encoding and default widths.
package shared_timer_pkg;

    localparam int unsigned DEF_NREQ = 4;
    localparam int unsigned DEF_CW   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/shared_timer_arbiter_if.sv
// Client-side bundle of the shared timer arbiter: requests/lengths in, grant/done/busy/count out.
interface shared_timer_arbiter_if
    import shared_timer_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned CW   = DEF_CW
);

    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [CW-1:0]      count;

    modport master (
        output req, len,
        input  gnt, done, busy, count
    );

    modport slave (
        input  req, len,
        output gnt, done, busy, count
    );

endinterface

// File: rtl/up_counter_en.sv
// Up counter with synchronous clear (dominant) and count enable.
module up_counter_en #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/shared_timer_arbiter.sv
// Round-robin arbiter sharing one up counter between NREQ interval-timing clients.
module shared_timer_arbiter
    import shared_timer_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned CW   = DEF_CW
) (
    input  logic                  clk,
    input  logic                  reset,
    shared_timer_arbiter_if.slave bus
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   win_q, win_d;
    logic [CW-1:0]   len_q, len_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;

    logic [PW-1:0]   pick_c;
    logic [PW-1:0]   win_next_c;
    logic            cnt_clr_c;
    logic            cnt_en_c;
    logic [CW-1:0]   count_c;

    // Addition modulo NREQ; both operands are already below NREQ.
    function automatic logic [PW-1:0] mod_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (PW+1)'(NREQ)) begin
            s = s - (PW+1)'(NREQ);
        end
        return s[PW-1:0];
    endfunction

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin : rr_pick
        logic [NREQ-1:0] rot;
        logic [PW-1:0]   off;
        logic            found;
        rot   = NREQ'({bus.req, bus.req} >> ptr_q);
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (rot[i] && !found) begin
                off   = PW'(i);
                found = 1'b1;
            end
        end
        pick_c = mod_add(ptr_q, off);
    end

    assign win_next_c = mod_add(win_q, PW'(1));

    up_counter_en #(.CW(CW)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (cnt_clr_c),
        .en_i    (cnt_en_c),
        .count_o (count_c)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        len_d     = len_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        cnt_clr_c = 1'b1;
        cnt_en_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    win_d   = pick_c;
                    len_d   = bus.len[int'(pick_c)*CW +: CW];
                    gnt_d   = NREQ'(1) << pick_c;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Abort has priority over reaching the terminal count.
                if (!bus.req[win_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = win_next_c;
                end else if (count_c == len_q) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                end else begin
                    cnt_clr_c = 1'b0;
                    cnt_en_c  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = win_next_c;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            len_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            len_q   <= len_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_c;

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Scoreboard bench for shared_timer_arbiter: episodes push expected outcomes, a monitor pops and checks.
module tb_shared_timer_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 4;

    typedef struct {
        int win;
        int last;
        bit done;
        int cycles;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    shared_timer_arbiter_if #(.NREQ(NREQ), .CW(CW)) bus ();

    shared_timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    int   ptr_m    = 0;

    task automatic chk(input string name, input int act, input int req_v);
        n_checks++;
        if (act == req_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req_v, $time);
    endtask

    // Reference arbitration: first requester at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (ptr + k) % NREQ;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    // Monitor: observes one busy window at a time and compares it with the queue head.
    bit              in_txn = 1'b0;
    int              m_win, m_last, m_cycles, m_exp_cnt;
    bit              m_done;
    logic [NREQ-1:0] m_gnt;

    always @(negedge clk) begin
        if (!mon_en) begin
            in_txn = 1'b0;
        end else begin
            chk("busy_eq_or_gnt", int'(bus.busy), int'(bus.gnt != '0));
            if (!bus.busy) begin
                chk("idle_count_zero", int'(bus.count), 0);
                chk("idle_done_zero", int'(bus.done), 0);
            end
            if (!in_txn && bus.gnt != '0) begin
                in_txn    = 1'b1;
                m_gnt     = bus.gnt;
                m_win     = -1;
                for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) m_win = i;
                m_exp_cnt = 0;
                m_cycles  = 0;
                m_last    = -1;
                m_done    = 1'b0;
            end
            if (in_txn) begin
                if (bus.gnt == '0) begin
                    exp_t e;
                    in_txn = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("winner", m_win, e.win);
                        chk("last_count", m_last, e.last);
                        chk("done_seen", int'(m_done), int'(e.done));
                        chk("busy_cycles", m_cycles, e.cycles);
                    end
                end else begin
                    m_cycles++;
                    chk("gnt_onehot", int'($onehot(bus.gnt)), 1);
                    if (m_cycles > 1) chk("gnt_hold", int'(bus.gnt), int'(m_gnt));
                    if (bus.done != '0) begin
                        m_done = 1'b1;
                        chk("done_eq_gnt", int'(bus.done), int'(m_gnt));
                        chk("done_count_zero", int'(bus.count), 0);
                    end else begin
                        chk("count_seq", int'(bus.count), m_exp_cnt);
                        m_last = int'(bus.count);
                        m_exp_cnt++;
                    end
                end
            end
        end
    end

    // One arbitration episode; called at a negedge, returns at a negedge.
    task automatic episode(input logic [NREQ-1:0] mask, input logic [NREQ*CW-1:0] lens,
                           input bit do_abort, input int abort_at_in);
        exp_t e;
        int   w, l, a;
        bit   ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("idle_wait", int'(ok), 1);
        if (!ok) return;
        w = rr_pick(mask, ptr_m);
        l = int'(lens[w*CW +: CW]);
        a = (abort_at_in > l) ? l : abort_at_in;
        e.win    = w;
        e.done   = !do_abort;
        e.last   = do_abort ? a : l;
        e.cycles = do_abort ? a + 1 : l + 2;
        exp_q.push_back(e);
        ptr_m   = (w + 1) % NREQ;
        bus.req = mask;
        bus.len = lens;
        @(negedge clk);
        chk("grant_latency", int'(bus.gnt), 1 << w);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done != '0) begin
                ok = 1'b1;
                break;
            end
            if (do_abort && int'(bus.count) == a) begin
                bus.req[w] = 1'b0;
                ok = 1'b1;
                break;
            end
            // Length and other requesters may change freely while the winner runs.
            bus.len = (NREQ*CW)'($urandom);
            bus.req = NREQ'($urandom) | (NREQ'(1) << w);
            @(negedge clk);
        end
        chk("episode_end", int'(ok), 1);
    endtask

    initial begin
        logic [NREQ-1:0]    rmask;
        logic [NREQ*CW-1:0] rlens;
        bit                 ok;

        reset   = 1'b1;
        bus.req = 4'hF;
        bus.len = '0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_gnt", int'(bus.gnt), 0);
            chk("rst_done", int'(bus.done), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_count", int'(bus.count), 0);
        end
        reset  = 1'b0;
        ptr_m  = 0;
        mon_en = 1'b1;

        episode(4'hF, {4'd1, 4'd1, 4'd1, 4'd2}, 1'b0, 0);
        episode(4'b0001, {4'd0, 4'd0, 4'd0, 4'd3}, 1'b0, 0);
        repeat (4) episode(4'b0101, {4'd1, 4'd1, 4'd1, 4'd1}, 1'b0, 0);
        episode(4'b1000, {4'd0, 4'd5, 4'd5, 4'd5}, 1'b0, 0);
        episode(4'b0010, {4'd0, 4'd0, 4'd9, 4'd0}, 1'b1, 2);
        episode(4'b0110, {4'd0, 4'd2, 4'd3, 4'd0}, 1'b0, 0);
        episode(4'b0001, {4'd0, 4'd0, 4'd0, 4'd15}, 1'b0, 0);

        repeat (60) begin
            rmask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            rlens = (NREQ*CW)'($urandom);
            episode(rmask, rlens, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)));
        end

        // Leave the pointer at 3, then reset in the middle of a run.
        episode(4'b0100, {4'd0, 4'd1, 4'd0, 4'd0}, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        mon_en  = 1'b0;
        bus.req = 4'b0001;
        bus.len = {4'd0, 4'd0, 4'd0, 4'd15};
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.busy && int'(bus.count) == 5) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_count5", int'(ok), 1);
        reset   = 1'b1;
        bus.req = 4'hF;
        @(negedge clk);
        chk("midrst_gnt", int'(bus.gnt), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_count", int'(bus.count), 0);
        reset  = 1'b0;
        ptr_m  = 0;
        mon_en = 1'b1;
        episode(4'hF, {4'd2, 4'd2, 4'd2, 4'd2}, 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
